fetch_unit: RTL

Parametrised instruction fetch stage with decoupled memory and decode interfaces. It issues sequential fetch requests over a valid/ready request channel and accepts in-order responses with variable latency. Fetched instructions are buffered with their PCs in a DEPTH-entry queue feeding decode through valid/ready. Branch/jump redirects flush the queue and discard stale in-flight responses. It sits between the PC-redirect logic from execute and the decode stage, replacing the single-cycle combinational-memory fetch.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch stage with credit-limited
// requests, in-order responses and a DEPTH-entry PC/instruction queue.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_req_valid,
  input  logic            i_req_ready,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_rsp_valid,
  input  logic [ILEN-1:0] i_rsp_data,
  input  logic            i_rsp_err,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr,
  output logic            o_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(ILEN / 8);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            err;
  } entry_t;

  entry_t          q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redir_pc;

  logic credit;
  logic req_fire;
  logic rsp_ok;
  logic rsp_keep;
  logic pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // In-flight requests count against queue space so a push never overflows.
  always_comb begin
    credit   = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
    redir_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
    o_req_valid = !i_rst && !i_redirect && credit;
    o_req_addr  = fetch_pc;
    req_fire = o_req_valid && i_req_ready;
    rsp_ok   = i_rsp_valid && (outstanding != '0);
    rsp_keep = rsp_ok && (drop_cnt == '0) && !i_redirect;
    o_valid  = (count != '0);
    pop      = o_valid && i_ready && !i_redirect;
    o_pc     = q[head].pc;
    o_instr  = q[head].instr;
    o_err    = q[head].err;
  end

  // Control state: PCs, credit counters, stale-drop count, queue pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (i_redirect) begin
      fetch_pc    <= redir_pc;
      rsp_pc      <= redir_pc;
      outstanding <= outstanding - CW'(rsp_ok);
      drop_cnt    <= outstanding - CW'(rsp_ok);
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + STEP;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
      if (rsp_keep) begin
        tail   <= nxt(tail);
        rsp_pc <= rsp_pc + STEP;
      end
      if (pop)
        head <= nxt(head);
      count <= count + CW'(rsp_keep) - CW'(pop);
    end
  end

  // Queue storage: needs no reset, count gates visibility.
  always_ff @(posedge i_clk) begin
    if (!i_rst && rsp_keep)
      q[tail] <= '{pc: rsp_pc, instr: i_rsp_data, err: i_rsp_err};
  end

  // A response with nothing in flight is a memory-side protocol error.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_rsp_valid)
      assert (outstanding != '0);
  end

endmodule
